// File: rtl/fir_serial_mac_if.sv
// Sample/coefficient/result bundle of the serial-MAC FIR engine.
// The master side feeds samples and coefficients; the slave side is the engine.
interface fir_serial_mac_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 12,
    parameter int unsigned CW = 12,
    parameter int unsigned OW = 29
);
    logic                 din_valid;
    logic signed [DW-1:0] din;
    logic                 din_ready;
    logic [AW-1:0]        co_choose;
    logic signed [CW-1:0] co_in;
    logic signed [OW-1:0] dout;
    logic                 dout_valid;

    modport master (
        output din_valid, din, co_in,
        input  din_ready, co_choose, dout, dout_valid
    );

    modport slave (
        input  din_valid, din, co_in,
        output din_ready, co_choose, dout, dout_valid
    );
endinterface

// File: rtl/fir_serial_mac.sv
// Serial multiply-accumulate FIR: one multiply per cycle over a TAPS-deep sample ring.
// Optional saturating accumulation is enabled by defining FIR_SAT_EN.
module fir_serial_mac #(
    parameter int unsigned TAPS = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 12,
    parameter int unsigned CW   = 12,
    parameter int unsigned OW   = 29
) (
    input  logic            clk,
    input  logic            rst_n,
    fir_serial_mac_if.slave bus
);
    localparam int unsigned PW = DW + CW;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t               state;
    logic signed [DW-1:0] buffer [TAPS];
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        base;
    logic [AW-1:0]        k;
    logic [AW-1:0]        rd_idx;
    logic signed [DW-1:0] samp_d;
    logic                 acc_en;
    logic                 acc_first;
    logic signed [OW-1:0] acc;
    logic signed [OW-1:0] acc_next;
    logic signed [OW-1:0] dout;
    logic                 dout_valid;
    logic signed [PW-1:0] prod_full;

    // Newest sample sits at base; tap k reads k entries back, wrapping in the ring.
    assign rd_idx         = base - k;
    assign bus.din_ready  = (state == IDLE);
    assign bus.co_choose  = k;
    assign bus.dout       = dout;
    assign bus.dout_valid = dout_valid;

    assign prod_full = PW'(samp_d) * PW'(bus.co_in);

`ifdef FIR_SAT_EN
    localparam int unsigned EW = ((PW > OW) ? PW : OW) + 1;
    localparam logic signed [EW-1:0] MAXV = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [OW-1:0] prod_s;
    logic signed [EW-1:0] sum_w;

    function automatic logic signed [OW-1:0] sat_ow(input logic signed [EW-1:0] v);
        if (v > MAXV) begin
            return MAXV[OW-1:0];
        end else if (v < MINV) begin
            return MINV[OW-1:0];
        end
        return v[OW-1:0];
    endfunction

    // Clamp the product first, then the running sum, in a width that cannot overflow.
    always_comb begin
        prod_s = sat_ow(EW'(prod_full));
        sum_w  = EW'(prod_s);
        if (!acc_first) begin
            sum_w = sum_w + EW'(acc);
        end
        acc_next = sat_ow(sum_w);
    end
`else
    always_comb begin
        acc_next = OW'(prod_full);
        if (!acc_first) begin
            acc_next = acc + OW'(prod_full);
        end
    end
`endif

    // Issue stage steps k and fetches the sample; accumulate stage trails it by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wptr       <= '0;
            base       <= '0;
            k          <= '0;
            samp_d     <= '0;
            acc_en     <= 1'b0;
            acc_first  <= 1'b0;
            acc        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            for (int i = 0; i < int'(TAPS); i++) begin
                buffer[i] <= '0;
            end
        end else begin
            dout_valid <= 1'b0;
            acc_en     <= 1'b0;
            acc_first  <= 1'b0;
            if (acc_en) begin
                acc <= acc_next;
            end
            case (state)
                IDLE: begin
                    k <= '0;
                    if (bus.din_valid && bus.din_ready) begin
                        buffer[wptr] <= bus.din;
                        base         <= wptr;
                        wptr         <= wptr + AW'(1);
                        state        <= RUN;
                    end
                end
                RUN: begin
                    samp_d    <= buffer[rd_idx];
                    acc_en    <= 1'b1;
                    acc_first <= (k == '0);
                    k         <= k + AW'(1);
                    if (k == AW'(TAPS - 1)) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    dout       <= acc_next;
                    dout_valid <= 1'b1;
                    k          <= '0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed bench for fir_serial_mac: impulse, step, extremes, handshake timing,
// mid-run reset and a narrow-accumulator instance for wrap/saturation.
module tb_fir_serial_mac;
    localparam int unsigned TAPS = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 12;
    localparam int unsigned CW   = 12;
    localparam int unsigned OW   = 29;
    localparam int unsigned OWS  = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic signed [CW-1:0] coef [TAPS];

    fir_serial_mac_if #(.AW(AW), .DW(DW), .CW(CW), .OW(OW))  bus ();
    fir_serial_mac_if #(.AW(AW), .DW(DW), .CW(CW), .OW(OWS)) bus_s ();

    fir_serial_mac #(.TAPS(TAPS), .AW(AW), .DW(DW), .CW(CW), .OW(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fir_serial_mac #(.TAPS(TAPS), .AW(AW), .DW(DW), .CW(CW), .OW(OWS)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    always #5 clk = ~clk;

    // Registered coefficient memory: data follows the index by one cycle.
    always @(posedge clk) bus.co_in <= coef[bus.co_choose];

    task automatic set_coef(input int mode);
        for (int i = 0; i < int'(TAPS); i++) begin
            case (mode)
                0:       coef[i] = CW'(i + 1);
                1:       coef[i] = CW'(1);
                default: coef[i] = CW'(-2048);
            endcase
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        bus.din_valid   = 1'b0;
        bus.din         = '0;
        bus_s.din_valid = 1'b0;
        bus_s.din       = '0;
        rst_n           = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Starts and ends on a falling edge; returns at the cycle dout_valid is seen.
    task automatic run_sample(input logic signed [DW-1:0] x, output logic signed [OW-1:0] y,
                              input string tag);
        int n;
        n = 0;
        while (!bus.din_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.din       = x;
        bus.din_valid = 1'b1;
        @(negedge clk);
        bus.din_valid = 1'b0;
        n = 0;
        while (!bus.dout_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: dout_valid=%b required 1", tag, bus.dout_valid);
            y = 'x;
        end else begin
            y = bus.dout;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.din_ready !== 1'b1) begin
            errors++; $display("FAIL reset din_ready=%b required 1", bus.din_ready);
        end
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            errors++; $display("FAIL reset dout_valid=%b required 0", bus.dout_valid);
        end
        checks++;
        if (bus.dout !== OW'(0)) begin
            errors++; $display("FAIL reset dout=%0d required 0", bus.dout);
        end
        checks++;
        if (bus.co_choose !== AW'(0)) begin
            errors++; $display("FAIL reset co_choose=%0d required 0", bus.co_choose);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_impulse;
        logic signed [OW-1:0] y;
        logic signed [OW-1:0] exp_y;
        set_coef(0);
        do_reset();
        for (int i = 0; i < 34; i++) begin
            run_sample(DW'(i == 0), y, "impulse");
            exp_y = (i < 32) ? OW'(i + 1) : OW'(0);
            checks++;
            if (y !== exp_y) begin
                errors++; $display("FAIL impulse[%0d] dout=%0d required %0d", i, y, exp_y);
            end
            @(negedge clk);
            checks++;
            if (bus.dout_valid !== 1'b0) begin
                errors++; $display("FAIL impulse_pulse[%0d] dout_valid=%b required 0", i, bus.dout_valid);
            end
        end
    endtask

    task automatic test_step;
        logic signed [OW-1:0] y;
        logic signed [OW-1:0] exp_y;
        set_coef(1);
        do_reset();
        for (int i = 0; i < 34; i++) begin
            run_sample(DW'(100), y, "step");
            exp_y = OW'(100 * ((i < 32) ? i + 1 : 32));
            checks++;
            if (y !== exp_y) begin
                errors++; $display("FAIL step[%0d] dout=%0d required %0d", i, y, exp_y);
            end
        end
    endtask

    task automatic test_extremes;
        logic signed [OW-1:0] y;
        set_coef(2);
        do_reset();
        y = '0;
        for (int i = 0; i < 32; i++) begin
            run_sample(DW'(-2048), y, "extremes");
        end
        checks++;
        if (y !== OW'(134217728)) begin
            errors++; $display("FAIL extremes dout=%0d required 134217728", y);
        end
    endtask

    // din_valid held high: one accept per 34 cycles; busy-time din must be dropped.
    task automatic test_timing;
        int r;
        logic signed [OW-1:0] exp_y;
        set_coef(0);
        do_reset();
        bus.din       = DW'(1);
        bus.din_valid = 1'b1;
        for (int c = 1; c <= 68; c++) begin
            @(negedge clk);
            r = (c <= 34) ? c : c - 34;
            if (r == 1) bus.din = DW'(555);
            if (r <= 32) begin
                checks++;
                if (bus.co_choose !== AW'(r - 1)) begin
                    errors++; $display("FAIL timing_co_choose[c%0d] co_choose=%0d required %0d", c, bus.co_choose, r - 1);
                end
            end
            if (r <= 33) begin
                checks++;
                if ({bus.din_ready, bus.dout_valid} !== 2'b00) begin
                    errors++; $display("FAIL timing_busy[c%0d] ready,valid=%b required 00", c, {bus.din_ready, bus.dout_valid});
                end
            end else begin
                exp_y = (c == 34) ? OW'(1) : OW'(2);
                checks++;
                if ({bus.din_ready, bus.dout_valid} !== 2'b11) begin
                    errors++; $display("FAIL timing_done[c%0d] ready,valid=%b required 11", c, {bus.din_ready, bus.dout_valid});
                end
                checks++;
                if (bus.dout !== exp_y) begin
                    errors++; $display("FAIL timing_dout[c%0d] dout=%0d required %0d", c, bus.dout, exp_y);
                end
                if (c == 34) bus.din = DW'(0);
                else bus.din_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if ({bus.din_ready, bus.dout_valid} !== 2'b10) begin
            errors++; $display("FAIL timing_idle ready,valid=%b required 10", {bus.din_ready, bus.dout_valid});
        end
    endtask

    task automatic test_reset_mid_run;
        logic signed [OW-1:0] y;
        int seen;
        set_coef(0);
        do_reset();
        bus.din       = DW'(5);
        bus.din_valid = 1'b1;
        @(negedge clk);
        bus.din_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.din_ready, bus.co_choose} !== {1'b1, AW'(0)}) begin
            errors++; $display("FAIL midreset_async ready=%b co_choose=%0d required 1,0", bus.din_ready, bus.co_choose);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.dout_valid === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL midreset_no_valid pulses=%0d required 0", seen);
        end
        run_sample(DW'(1), y, "midreset_impulse");
        checks++;
        if (y !== OW'(1)) begin
            errors++; $display("FAIL midreset_impulse dout=%0d required 1", y);
        end
    endtask

    task automatic test_saturation;
        logic signed [OWS-1:0] y;
        logic signed [OWS-1:0] exp_y;
        int n;
`ifdef FIR_SAT_EN
        exp_y = OWS'(524287);
`else
        exp_y = OWS'(-131040);
`endif
        do_reset();
        y = '0;
        for (int i = 0; i < 32; i++) begin
            n = 0;
            while (!bus_s.din_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            bus_s.din       = DW'(2047);
            bus_s.din_valid = 1'b1;
            @(negedge clk);
            bus_s.din_valid = 1'b0;
            n = 0;
            while (!bus_s.dout_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            y = bus_s.dout_valid ? bus_s.dout : 'x;
        end
        checks++;
        if (y !== exp_y) begin
            errors++; $display("FAIL saturation dout=%0d required %0d", y, exp_y);
        end
    endtask

    initial begin
        bus.din_valid   = 1'b0;
        bus.din         = '0;
        bus_s.din_valid = 1'b0;
        bus_s.din       = '0;
        bus_s.co_in     = CW'(2047);
        set_coef(0);
        test_reset();
        test_impulse();
        test_step();
        test_extremes();
        test_timing();
        test_reset_mid_run();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
